// File: rtl/parity_req_arbiter_if.sv
// Request/response bundle between the client blocks and the shared parity engine.
// Clients drive the master side; the arbiter sits on the slave side.
interface parity_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_odd;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_parity;
  logic                      busy;

  modport master (
    output req_valid, req_data, req_odd, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_parity, busy
  );

  modport slave (
    input  req_valid, req_data, req_odd, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_parity, busy
  );
endinterface

// File: rtl/parity_req_arbiter.sv
// Round-robin front end for a shared multi-cycle parity engine. One request word is accepted
// at a time, folded CHUNK_W bits per cycle, and the parity is returned tagged with the id of
// the requester that supplied it.
module parity_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CHUNK_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  parity_req_arbiter_if.slave  bus
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned BEATS = DATA_W / CHUNK_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Reject configurations the folding datapath cannot handle.
  if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
    $fatal(1, "parity_req_arbiter: DATA_W must be a multiple of CHUNK_W");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $fatal(1, "parity_req_arbiter: NUM_REQ must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e              r_state;
  logic [ID_W-1:0]     r_last_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_acc;
  logic                r_odd;
  logic [DATA_W-1:0]   r_word;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic                r_rsp_parity;
  logic                r_busy;

  logic                w_grant_found;
  logic [ID_W-1:0]     w_grant_idx;
  logic [NUM_REQ-1:0]  w_grant_vec;
  logic [CHUNK_W-1:0]  w_chunk;
  logic                w_chunk_par;
  logic                w_last_beat;

  // Round-robin search starting just after the previous winner; the winner is
  // advertised only while idle and out of reset.
  always_comb begin
    int unsigned idx;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_grant_vec   = '0;
    idx           = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(r_last_grant) + k) % NUM_REQ;
      if (!w_grant_found && bus.req_valid[ID_W'(idx)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = ID_W'(idx);
      end
    end
    if (rst_n && (r_state == StIdle) && w_grant_found) begin
      w_grant_vec[w_grant_idx] = 1'b1;
    end
  end

  // Current chunk of the captured word and its XOR reduction.
  always_comb begin
    w_chunk     = r_word[32'(r_cnt) * CHUNK_W +: CHUNK_W];
    w_chunk_par = ^w_chunk;
    w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
  end

  // Sequencer: accept, fold BEATS chunks, hold the response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_cnt        <= '0;
      r_acc        <= 1'b0;
      r_odd        <= 1'b0;
      r_word       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_parity <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant_found) begin
            r_word       <= bus.req_data[32'(w_grant_idx) * DATA_W +: DATA_W];
            r_odd        <= bus.req_odd[w_grant_idx];
            r_last_grant <= w_grant_idx;
            r_acc        <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= StCalc;
          end
        end
        StCalc: begin
          r_acc <= r_acc ^ w_chunk_par;
          r_cnt <= r_cnt + 1'b1;
          if (w_last_beat) begin
            // Final fold goes straight into the registered response.
            r_rsp_valid  <= 1'b1;
            r_rsp_parity <= r_acc ^ w_chunk_par ^ r_odd;
            r_rsp_id     <= r_last_grant;
            r_state      <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_parity <= 1'b0;
            r_rsp_id     <= '0;
            r_busy       <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_grant_vec;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_parity = r_rsp_parity;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_parity_req_arbiter.sv
// Bench for parity_req_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a cycle-level reference model built from the arbitration rules.
module tb_parity_req_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int BEATS = DW / CW;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  parity_req_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  parity_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CHUNK_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        odd;
    logic        exp_par;
  } vec_t;

  vec_t vecs[8];

  function automatic logic ref_par(input logic [31:0] d, input logic o);
    return ((($countones(d) + int'(o)) % 2) == 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_odd   = '0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({nm, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({nm, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
    chk({nm, "_rsp_parity"}, 64'(bus.rsp_parity), 64'd0);
    chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  // One isolated transaction from an idle arbiter with a single requester active.
  task automatic run_txn(input int id, input logic [31:0] data, input logic odd,
                         input logic exp_par, input string nm);
    @(negedge clk);
    bus.req_valid              = 4'(1 << id);
    bus.req_data[id*DW +: DW]  = data;
    bus.req_odd[id]            = odd;
    bus.rsp_ready              = 1'b0;
    #1;
    chk({nm, "_ready"}, 64'(bus.req_ready), 64'(1 << id));
    @(negedge clk);
    bus.req_valid = '0;
    chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
    chk({nm, "_early0"}, 64'(bus.rsp_valid), 64'd0);
    for (int e = 1; e < BEATS; e++) begin
      @(negedge clk);
      chk({nm, "_early"}, 64'(bus.rsp_valid), 64'd0);
    end
    @(negedge clk);
    chk({nm, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({nm, "_rsp_id"}, 64'(bus.rsp_id), 64'(id));
    chk({nm, "_rsp_parity"}, 64'(bus.rsp_parity), 64'(exp_par));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_drop"}, 64'(bus.rsp_valid), 64'd0);
    chk({nm, "_idle"}, 64'(bus.busy), 64'd0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic        o;
    logic        ep;
    int          g_id[5];
    int          g_cyc[5];
    int          ng;
    int          n;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_inputs();

    // T1: outputs forced low during reset whatever the inputs do.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_valid = 4'($urandom);
      bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.req_odd   = 4'($urandom);
      bus.rsp_ready = 1'($urandom);
      #1;
      chk_all_zero("t1_reset");
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    w = $urandom;
    run_txn(3, w, 1'b0, ref_par(w, 1'b0), "t1_first");

    // Directed vectors: T2 and T5 cases plus a few extra patterns.
    vecs[0] = '{0, 32'h0000_0001, 1'b0, 1'b1};
    vecs[1] = '{1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{2, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{3, 32'h8000_0000, 1'b1, 1'b0};
    vecs[4] = '{0, 32'h0000_0003, 1'b0, 1'b0};
    vecs[5] = '{1, 32'h0101_0101, 1'b1, 1'b1};
    vecs[6] = '{2, 32'h0700_0000, 1'b0, 1'b1};
    vecs[7] = '{3, 32'h0000_0000, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].id, vecs[i].data, vecs[i].odd, vecs[i].exp_par,
              $sformatf("vec%0d", i));
    end

    // T3: all requesters held valid -> rotating grants, BEATS+2 cycles apart.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = $urandom;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) g_id[ng] = i;
        g_cyc[ng] = c;
        ng++;
      end
      @(negedge clk);
    end
    chk("t3_grant_count", 64'(ng), 64'd5);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("t3_order%0d", i), 64'(g_id[i]), 64'(i % NR));
      if (i > 0) chk($sformatf("t3_gap%0d", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'(BEATS + 2));
    end

    // T4: response held under backpressure, requests blocked meanwhile.
    do_reset();
    @(negedge clk);
    w = $urandom;
    o = 1'($urandom);
    ep = ref_par(w, o);
    bus.req_data[1*DW +: DW] = w;
    bus.req_odd[1]           = o;
    bus.req_valid            = 4'b0010;
    bus.rsp_ready            = 1'b0;
    @(negedge clk);
    bus.req_valid = '0;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_rsp_arrive", 64'(bus.rsp_valid), 64'd1);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t4_hold_id", 64'(bus.rsp_id), 64'd1);
      chk("t4_hold_parity", 64'(bus.rsp_parity), 64'(ep));
      chk("t4_no_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t4_release_busy", 64'(bus.busy), 64'd0);
    #1;
    chk("t4_next_grant", 64'(bus.req_ready), 64'b0100);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // T6: reset in the middle of a req2 fold discards it.
    do_reset();
    @(negedge clk);
    bus.req_data[2*DW +: DW] = 32'h0000_0001;
    bus.req_valid            = 4'b0100;
    #1;
    chk("t6_ready2", 64'(bus.req_ready), 64'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < BEATS + 1; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    bus.req_valid = 4'b0110;
    #1;
    chk("t6_grant1", 64'(bus.req_ready), 64'b0010);
    bus.req_valid = '0;
    w = $urandom;
    run_txn(1, w, 1'b1, ref_par(w, 1'b1), "t6_after");

    // Randomized run against the reference model.
    do_reset();
    begin
      logic [NR-1:0] v;
      logic [31:0]   d[NR];
      logic          od[NR];
      int            m_phase;  // 0 idle, 1 folding, 2 response pending
      int            m_left;
      int            m_id;
      logic          m_par;
      int            m_last;
      int            m_gnt;
      int            idx;
      v       = '0;
      m_phase = 0;
      m_left  = 0;
      m_id    = 0;
      m_par   = 1'b0;
      m_last  = NR - 1;
      m_gnt   = -1;
      for (int i = 0; i < NR; i++) begin
        d[i]  = '0;
        od[i] = 1'b0;
      end
      for (int cyc = 0; cyc < 800; cyc++) begin
        @(negedge clk);
        chk("rnd_rsp_valid", 64'(bus.rsp_valid), 64'(m_phase == 2));
        chk("rnd_busy", 64'(bus.busy), 64'(m_phase != 0));
        if (m_phase == 2) begin
          chk("rnd_rsp_id", 64'(bus.rsp_id), 64'(m_id));
          chk("rnd_rsp_parity", 64'(bus.rsp_parity), 64'(m_par));
        end
        if (m_gnt >= 0) v[m_gnt] = 1'b0;
        for (int i = 0; i < NR; i++) begin
          if (!v[i] && $urandom_range(2) == 0) begin
            v[i]  = 1'b1;
            d[i]  = $urandom;
            od[i] = 1'($urandom_range(1));
          end
          bus.req_data[i*DW +: DW] = d[i];
          bus.req_odd[i]           = od[i];
        end
        bus.req_valid = v;
        bus.rsp_ready = 1'($urandom_range(1));
        #1;
        m_gnt = -1;
        if (m_phase == 0) begin
          for (int k = 1; k <= NR; k++) begin
            idx = (m_last + k) % NR;
            if (m_gnt < 0 && v[idx]) m_gnt = idx;
          end
        end
        chk("rnd_req_ready", 64'(bus.req_ready), (m_gnt >= 0) ? 64'(1 << m_gnt) : 64'd0);
        if (m_phase == 0 && m_gnt >= 0) begin
          m_phase = 1;
          m_left  = BEATS;
          m_id    = m_gnt;
          m_last  = m_gnt;
          m_par   = ref_par(d[m_gnt], od[m_gnt]);
        end else if (m_phase == 1) begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end else if (m_phase == 2 && bus.rsp_ready) begin
          m_phase = 0;
        end
      end
    end

    @(negedge clk);
    clear_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
